tocador_musica: RTL
===================

# tocador_musica

Playback sequencer that steps through one song stored in the song memory (16 songs × N words of 4-bit nota / 4-bit tempo) and presents each note for its programmed duration. It drives the memory's `musica` selector and `addr` bus, consumes `nota`, `tempo` and `fim_musica` (one-cycle synchronous read latency), and feeds the note generator / audio stage downstream. Duration is measured in `tick` pulses from the shared time base.

## Interface
- `N`, 256: words per song; address width is `$clog2(N)`.
- `TICKS_POR_TEMPO`, 4: `tick` pulses per tempo unit.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: one-cycle start request; honoured only in IDLE.
- `parar` in 1: abort; honoured in any state.
- `musica_sel` in 4: song to play; sampled when `iniciar` is accepted.
- `tick` in 1: one-cycle time-base pulse.
- `nota_mem` in 4: memory note output.
- `tempo_mem` in 4: memory tempo output.
- `fim_musica_mem` in 1: memory end marker (nota = 0 and tempo = 0).
- `musica` out 4: song selector to memory, registered.
- `addr` out `$clog2(N)`: word address to memory, registered.
- `nota` out 4: current note to the tone generator.
- `nota_valida` out 1: a non-rest note is sounding.
- `tocando` out 1: high in every state except IDLE.
- `fim` out 1: one-cycle pulse on natural end of song.
- `pausar` in 1: present only with `TOCADOR_PAUSA_EN`.

## Operation
- States: IDLE, LE, DECIDE, TOCA, FIM.
- Reset: state IDLE; `musica`=0, `addr`=0, `nota`=0, `nota_valida`=0, `tocando`=0, `fim`=0, duration and tick counters 0.
- IDLE: `iniciar`=1 and `parar`=0 → latch `musica_sel` into `musica`, `addr`←0, go to LE. If both are high, `parar` wins and the block stays in IDLE.
- LE: one wait cycle for the synchronous memory read. Always go to DECIDE.
- DECIDE: memory data for `addr` is valid.
  - `fim_musica_mem`=1 → go to FIM.
  - Otherwise:
    - `nota`←`nota_mem`; `nota_valida`←(`nota_mem`≠0), so nota 0 with nonzero tempo is a rest.
    - Tempo units = `tempo_mem`, or 16 when `tempo_mem`=0 and `nota_mem`≠0.
    - `dur`←units × `TICKS_POR_TEMPO`. The `dur` register is `4+$clog2(TICKS_POR_TEMPO)+1` bits and must not overflow.
    - Tick counter ←0; go to TOCA.
- TOCA: on each `tick`:
  - If counter = `dur`−1 and `addr` = N−1 → go to FIM. The last address is an end of song; there is no wrap.
  - If counter = `dur`−1 and `addr` < N−1 → `addr`←`addr`+1, go to LE.
  - Otherwise counter +1.
  - `tick` is ignored in LE, DECIDE and FIM.
- FIM: `fim`=1, `nota_valida`=0, `nota`=0 for one cycle, then IDLE. `musica` and `addr` hold their values.
- `parar` in LE, DECIDE, TOCA or FIM → next state IDLE. `nota_valida`, `nota` and `tocando` clear on that edge. No `fim` pulse is produced. `addr` and `musica` hold.
- `iniciar` outside IDLE is ignored.
- `reset_n` low at any time forces the reset values immediately, independent of `clk`.

## Timing
- All outputs are registered. No combinational paths from inputs to outputs.
- `iniciar` sampled at edge k: `tocando`=1 and `addr`=0 from k; state is LE during cycle k→k+1 and DECIDE during k+1→k+2.
- `nota` and `nota_valida` are valid from edge k+2.
- A note whose duration is D ticks sounds from its DECIDE edge until the edge that samples its D-th tick in TOCA.
- Between notes there are 2 cycles (LE, DECIDE) in which `nota` holds its old value. `nota_valida` also holds.
- `fim` is asserted the edge after the last tick or after DECIDE sees the end marker. It is exactly one cycle wide.

## Configuration
- `TOCADOR_PAUSA_EN` defined:
  - The `pausar` port exists.
  - While `pausar`=1 in TOCA, ticks are not counted and `nota_valida` is forced to 0. `nota` holds.
  - On release, counting resumes from the frozen count.
  - `pausar` has no effect in other states. `parar` overrides `pausar`.
- `TOCADOR_PAUSA_EN` not defined: the port is absent and behaviour is exactly as above without pause.

## Test plan
- Reset mid-TOCA (`reset_n` low between edges) → all outputs read 0 immediately, before the next clock.
- Song 3 = {(5,2),(0,1),(0,0)}, `TICKS_POR_TEMPO`=4, `iniciar` with `musica_sel`=3 → `musica`=3; `nota`=5 with `nota_valida`=1 for 8 ticks; then a rest (`nota_valida`=0) for 4 ticks; then one `fim` pulse; then `tocando`=0.
- Word (7,0) → note 7 lasts 64 ticks. First word (0,0) → `fim` at edge k+2 with `nota_valida` never high.
- N=4 with no end marker → addr 0,1,2,3, then FIM after the last duration; `addr` never wraps to 0.
- `parar` asserted during the second note → IDLE next edge, `nota_valida`=0, no `fim`. `iniciar`+`parar` together in IDLE → stays IDLE. `iniciar` during TOCA → ignored and `musica` unchanged.
- With `TOCADOR_PAUSA_EN`: `pausar` high for 10 ticks during a 4-tick note after 2 ticks → `nota_valida`=0 while paused, then the note ends exactly 2 ticks after release.

Source files
------------

// File: rtl/tocador_musica.sv
// tocador_musica: steps through one song of the song memory and presents each note for its duration in tick pulses.
// Define TOCADOR_PAUSA_EN to add the pausar input, which freezes the note timer and mutes nota_valida.
module tocador_musica #(
    parameter int N               = 256,
    parameter int TICKS_POR_TEMPO = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iniciar,
    input  logic                 parar,
`ifdef TOCADOR_PAUSA_EN
    input  logic                 pausar,
`endif
    input  logic [3:0]           musica_sel,
    input  logic                 tick,
    input  logic [3:0]           nota_mem,
    input  logic [3:0]           tempo_mem,
    input  logic                 fim_musica_mem,
    output logic [3:0]           musica,
    output logic [$clog2(N)-1:0] addr,
    output logic [3:0]           nota,
    output logic                 nota_valida,
    output logic                 tocando,
    output logic                 fim
);
    localparam int AW = $clog2(N);
    // Wide enough for 16 tempo units times TICKS_POR_TEMPO.
    localparam int DW = 4 + $clog2(TICKS_POR_TEMPO) + 1;
    localparam logic [AW-1:0] ULTIMO_ADDR = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LE,
        S_DECIDE,
        S_TOCA,
        S_FIM
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] dur, dur_next;
    logic [DW-1:0] cnt, cnt_next;
    logic [AW-1:0] addr_next;
    logic [3:0]    musica_next, nota_next;
    logic          nota_valida_next, fim_next;
    logic [4:0]    unidades;
    logic          pausado, tick_ok, fim_nota, ultimo_addr;

`ifdef TOCADOR_PAUSA_EN
    assign pausado = pausar;
`else
    assign pausado = 1'b0;
`endif

    assign tick_ok     = tick && !pausado;
    assign fim_nota    = tick_ok && (cnt == dur - DW'(1));
    assign ultimo_addr = (addr == ULTIMO_ADDR);

    // NOTE: asynchronous active-low reset; sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (parar) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (iniciar) state_next = S_LE;
                S_LE:     state_next = S_DECIDE;
                S_DECIDE: state_next = fim_musica_mem ? S_FIM : S_TOCA;
                S_TOCA:   if (fim_nota) state_next = ultimo_addr ? S_FIM : S_LE;
                S_FIM:    state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        musica_next      = musica;
        addr_next        = addr;
        nota_next        = nota;
        nota_valida_next = nota_valida;
        fim_next         = 1'b0;
        dur_next         = dur;
        cnt_next         = cnt;
        unidades         = (tempo_mem == 4'd0) ? 5'd16 : {1'b0, tempo_mem};
        if (parar) begin
            nota_next        = '0;
            nota_valida_next = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iniciar) begin
                        musica_next = musica_sel;
                        addr_next   = '0;
                    end
                end
                S_DECIDE: begin
                    if (fim_musica_mem) begin
                        nota_next        = '0;
                        nota_valida_next = 1'b0;
                        fim_next         = 1'b1;
                    end else begin
                        // Note 0 with a nonzero tempo is a rest: the timer runs but nothing sounds.
                        nota_next        = nota_mem;
                        nota_valida_next = (nota_mem != 4'd0);
                        dur_next         = DW'(unidades) * DW'(TICKS_POR_TEMPO);
                        cnt_next         = '0;
                    end
                end
                S_TOCA: begin
                    nota_valida_next = (nota != 4'd0) && !pausado;
                    if (tick_ok) begin
                        if (fim_nota) begin
                            if (ultimo_addr) begin
                                nota_next        = '0;
                                nota_valida_next = 1'b0;
                                fim_next         = 1'b1;
                            end else begin
                                addr_next = addr + AW'(1);
                            end
                        end else begin
                            cnt_next = cnt + DW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            musica      <= '0;
            addr        <= '0;
            nota        <= '0;
            nota_valida <= 1'b0;
            tocando     <= 1'b0;
            fim         <= 1'b0;
            dur         <= '0;
            cnt         <= '0;
        end else begin
            musica      <= musica_next;
            addr        <= addr_next;
            nota        <= nota_next;
            nota_valida <= nota_valida_next;
            tocando     <= (state_next != S_IDLE);
            fim         <= fim_next;
            dur         <= dur_next;
            cnt         <= cnt_next;
        end
    end

endmodule
